// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register for the pipelined MIPS core, with load-use hazard detection,
// branch flush, external hold and a saturating bubble counter.
module id_ex_pipeline_register #(
    parameter int unsigned N_BITS   = 32,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold_i,
    input  logic                flush_i,
    input  logic [10:0]         id_ctrl_i,
    input  logic [N_BITS-1:0]   id_rs_data_i,
    input  logic [N_BITS-1:0]   id_rt_data_i,
    input  logic [N_BITS-1:0]   id_imm_i,
    input  logic [4:0]          id_rs_i,
    input  logic [4:0]          id_rt_i,
    input  logic [4:0]          id_rd_i,
    output logic [10:0]         ex_ctrl_o,
    output logic [N_BITS-1:0]   ex_rs_data_o,
    output logic [N_BITS-1:0]   ex_rt_data_o,
    output logic [N_BITS-1:0]   ex_imm_o,
    output logic [4:0]          ex_rs_o,
    output logic [4:0]          ex_rt_o,
    output logic [4:0]          ex_rd_o,
    output logic                ex_valid_o,
    output logic                stall_o,
    output logic [CNT_BITS-1:0] bubble_cnt_o
);

    // Control word layout: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
    // BranchNE, BranchEQ, ALUOp[2:0]}
    localparam int unsigned MemReadBit = 6;

    logic [10:0]         ctrl_q;
    logic [N_BITS-1:0]   rs_data_q;
    logic [N_BITS-1:0]   rt_data_q;
    logic [N_BITS-1:0]   imm_q;
    logic [4:0]          rs_q;
    logic [4:0]          rt_q;
    logic [4:0]          rd_q;
    logic                valid_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                hazard;

    always_comb begin
        hazard = ctrl_q[MemReadBit] & valid_q & (rt_q != 5'd0) &
                 ((rt_q == id_rs_i) | (rt_q == id_rt_i));
        // A flushed instruction needs no stall, and hold freezes the pipe anyway.
        stall_o = hazard & ~flush_i & ~hold_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else if (!hold_i) begin
            if (flush_i || hazard) begin
                ctrl_q    <= '0;
                rs_data_q <= '0;
                rt_data_q <= '0;
                imm_q     <= '0;
                rs_q      <= '0;
                rt_q      <= '0;
                rd_q      <= '0;
                valid_q   <= 1'b0;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_BITS'(1);
                end
            end else begin
                ctrl_q    <= id_ctrl_i;
                rs_data_q <= id_rs_data_i;
                rt_data_q <= id_rt_data_i;
                imm_q     <= id_imm_i;
                rs_q      <= id_rs_i;
                rt_q      <= id_rt_i;
                rd_q      <= id_rd_i;
                valid_q   <= 1'b1;
            end
        end
    end

    assign ex_ctrl_o    = ctrl_q;
    assign ex_rs_data_o = rs_data_q;
    assign ex_rt_data_o = rt_data_q;
    assign ex_imm_o     = imm_q;
    assign ex_rs_o      = rs_q;
    assign ex_rt_o      = rt_q;
    assign ex_rd_o      = rd_q;
    assign ex_valid_o   = valid_q;
    assign bubble_cnt_o = cnt_q;

endmodule
